// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants and frame-buffer geometry shared by the scanout slice.
// Porch/sync widths are fixed; the visible sizes are defaults that the top may override.
package vga_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT       = 16;
  localparam int H_SYNC        = 96;
  localparam int H_BACK        = 48;
  localparam int H_TOTAL       = H_VISIBLE_DEF + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT       = 10;
  localparam int V_SYNC        = 2;
  localparam int V_BACK        = 33;
  localparam int V_TOTAL       = V_VISIBLE_DEF + V_FRONT + V_SYNC + V_BACK;

  localparam int FB_W_DEF = 320;
  localparam int FB_H     = 240;
  localparam int FB_DEPTH = FB_W_DEF * FB_H;
  localparam int FB_AW    = 17;

  // Row stride of 320 built from shifts: y*256 + y*64 + x.
  function automatic logic [FB_AW-1:0] fb_addr(input logic [8:0] x, input logic [7:0] y);
    logic [FB_AW-1:0] yw;
    yw = {9'd0, y};
    return (yw << 8) + (yw << 6) + {8'd0, x};
  endfunction

endpackage

// File: rtl/frame_buffer.sv
// 320x240x3 simple dual-port frame store: synchronous write, registered read (1 clock).
// Read-during-write to the same address returns the previous contents.
module frame_buffer
  import vga_pkg::*;
(
  input  logic             clock,
  input  logic             wr_en,
  input  logic [FB_AW-1:0] wr_addr,
  input  logic [2:0]       wr_data,
  input  logic [FB_AW-1:0] rd_addr,
  output logic [2:0]       rd_data
);

  logic [2:0] mem [0:FB_DEPTH-1];
  logic [2:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: pixel-doubled 320x240x3 frame buffer to 640x480 DAC/sync outputs.
// Colour and syncs leave one clock after the counters; pixel writes are never back-pressured.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int FB_W      = FB_W_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] x_position,
  input  logic [7:0] y_position,
  input  logic [2:0] colour,
  input  logic       VGA_enable,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK,
  output logic       frame_start
);

  localparam logic [9:0] H_VIS_C  = 10'(H_VISIBLE);
  localparam logic [9:0] H_SS_C   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SE_C   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST_C = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_VIS_C  = 10'(V_VISIBLE);
  localparam logic [9:0] V_PRE_C  = 10'(V_VISIBLE - 1);
  localparam logic [9:0] V_SS_C   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SE_C   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST_C = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [8:0] FB_W_C   = 9'(FB_W);
  localparam logic [7:0] FB_H_C   = 8'(FB_H);

  logic             pix_en_q, pix_en_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             blank_n_q, blank_n_d;
  logic             fs_q, fs_d;
  logic             visible;
  logic             wr_en;
  logic [FB_AW-1:0] wr_addr;
  logic [FB_AW-1:0] rd_addr;
  logic [2:0]       rd_data;

  always_comb begin
    pix_en_d = ~pix_en_q;
    h_d      = h_q;
    v_d      = v_q;
    fs_d     = 1'b0;
    if (pix_en_q) begin
      if (h_q == H_LAST_C) begin
        h_d  = '0;
        v_d  = (v_q == V_LAST_C) ? '0 : v_q + 10'd1;
        fs_d = (v_q == V_PRE_C);
      end else begin
        h_d = h_q + 10'd1;
      end
    end

    visible   = (h_q < H_VIS_C) && (v_q < V_VIS_C);
    hs_d      = ~((h_q >= H_SS_C) && (h_q < H_SE_C));
    vs_d      = ~((v_q >= V_SS_C) && (v_q < V_SE_C));
    blank_n_d = visible;
    // Parking the read address outside the visible area keeps it inside the RAM.
    rd_addr   = visible ? fb_addr(h_q[9:1], v_q[8:1]) : '0;

    wr_en   = VGA_enable && (x_position < FB_W_C) && (y_position < FB_H_C);
    wr_addr = fb_addr(x_position, y_position);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pix_en_q  <= 1'b0;
      h_q       <= '0;
      v_q       <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      pix_en_q  <= pix_en_d;
      h_q       <= h_d;
      v_q       <= v_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      fs_q      <= fs_d;
    end
  end

  frame_buffer u_fb (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (colour),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // The frame buffer is not reset, so blanking is what keeps the DAC quiet after reset.
  assign VGA_R       = {8{rd_data[2] & blank_n_q}};
  assign VGA_G       = {8{rd_data[1] & blank_n_q}};
  assign VGA_B       = {8{rd_data[0] & blank_n_q}};
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = pix_en_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunk 16x4 visible raster (porches and sync at full width).
// Every output is compared each clock against a cycle-indexed raster model, plus directed checks.
module tb_vga_scanout;

  localparam int HV    = 16;
  localparam int VV    = 4;
  localparam int HT    = HV + 16 + 96 + 48;   // 176 pixels per line
  localparam int VT    = VV + 10 + 2 + 33;    // 49 lines per frame
  localparam int PF    = HT * VT;             // pixels per frame
  localparam int FR    = 2 * PF;              // clocks per frame: 17248
  localparam int FS_K  = 2 * VV * HT;         // clock index of frame_start within a frame

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] x_position = '0;
  logic [7:0] y_position = '0;
  logic [2:0] colour = '0;
  logic       VGA_enable = 1'b0;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start;

  vga_scanout #(.H_VISIBLE(HV), .V_VISIBLE(VV), .FB_W(320)) dut (
    .clock       (clock),
    .reset       (reset),
    .x_position  (x_position),
    .y_position  (y_position),
    .colour      (colour),
    .VGA_enable  (VGA_enable),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N  (VGA_SYNC_N),
    .VGA_CLK     (VGA_CLK),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         k        = 0;   // clocks since the last clock edge that saw reset
  logic [2:0] fb_m [0:76799];
  logic       wr_pend = 1'b0;
  int         wr_pend_addr = 0;
  logic [2:0] wr_pend_col = '0;
  bit         measure = 1'b0;
  int         hs_low = 0, vs_low = 0, fs_cnt = 0, fs_prev = -1, fs_period = 0;
  int         kw;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d: got %h expected %h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [2:0] init_col(input int i);
    if (i == 0)  return 3'b100;
    if (i == 15) return 3'b001;
    return 3'((i * 3 + 2) % 8);
  endfunction

  // {R,G,B,HS,VS,BLANK_N,frame_start,VGA_CLK,SYNC_N} expected kk clocks after reset.
  function automatic logic [29:0] model(input int kk);
    int p, h, v;
    logic [2:0] c;
    logic hs, vs, vis, fs, ck;
    if (kk == 0) return {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    p   = ((kk - 1) / 2) % PF;
    h   = p % HT;
    v   = p / HT;
    vis = (h < HV) && (v < VV);
    c   = vis ? fb_m[(v / 2) * 320 + h / 2] : 3'b000;
    hs  = !((h >= HV + 16) && (h < HV + 112));
    vs  = !((v >= VV + 10) && (v < VV + 12));
    fs  = (kk % FR) == FS_K;
    ck  = (kk % 2) == 1;
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}, hs, vs, vis, fs, ck, 1'b0};
  endfunction

  task automatic tick();
    @(negedge clock);
    if (reset) k = 0;
    else k = k + 1;
    check_val("scan", {2'b00, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N,
                       frame_start, VGA_CLK, VGA_SYNC_N}, {2'b00, model(k)});
    if (measure) begin
      if (!VGA_HS) hs_low++;
      if (!VGA_VS) vs_low++;
      if (frame_start) begin
        if (fs_prev >= 0) fs_period = k - fs_prev;
        fs_prev = k;
        fs_cnt++;
      end
    end
    if (wr_pend) begin
      fb_m[wr_pend_addr] = wr_pend_col;
      wr_pend = 1'b0;
    end
    VGA_enable = 1'b0;
  endtask

  task automatic wr(input int x, input int y, input logic [2:0] c);
    x_position   = 9'(x);
    y_position   = 8'(y);
    colour       = c;
    VGA_enable   = 1'b1;
    wr_pend      = (x < 320) && (y < 240);
    wr_pend_addr = y * 320 + x;
    wr_pend_col  = c;
    tick();
  endtask

  task automatic run_to(input int target);
    while (k < target) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rgb"},   {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    check_val({tag, "_hs"},    32'(VGA_HS), 32'd1);
    check_val({tag, "_vs"},    32'(VGA_VS), 32'd1);
    check_val({tag, "_blank"}, 32'(VGA_BLANK_N), 32'd0);
    check_val({tag, "_fs"},    32'(frame_start), 32'd0);
    check_val({tag, "_clk"},   32'(VGA_CLK), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    check_reset_outputs("rst");
    check_val("sync_n", 32'(VGA_SYNC_N), 32'd0);

    // Load the displayed corner of the frame buffer while still in reset.
    for (int i = 0; i < 16; i++) wr(i % 8, i / 8, init_col(i));
    wr(319, 239, 3'b001);
    tick();
    reset = 1'b0;
    measure = 1'b1;

    tick();
    check_val("first_pix_rgb",   {8'h0, VGA_R, VGA_G, VGA_B}, 32'h00FF0000);
    check_val("first_pix_blank", 32'(VGA_BLANK_N), 32'd1);

    // Out-of-range writes must be dropped (320 would alias onto fb(0,1)).
    wr(320, 0, 3'b111);
    wr(0, 240, 3'b111);
    wr(511, 255, 3'b111);

    run_to(2 * (HT + 1) + 2);
    check_val("pix_1_1", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h00FF0000);
    run_to(2 * (2 * HT) + 2);
    check_val("pix_0_2_noalias", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0000FF00);
    run_to(2 * (3 * HT + 15) + 2);
    check_val("pix_corner", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h000000FF);

    run_to(2 * FR);
    measure = 1'b0;
    check_val("hs_low_clocks", 32'(hs_low), 32'd18816);
    check_val("vs_low_clocks", 32'(vs_low), 32'd1408);
    check_val("fs_count",      32'(fs_cnt), 32'd2);
    check_val("fs_period",     32'(fs_period), 32'd17248);

    // Overwrite fb(3,1) on the last clock that reads it this frame.
    kw = 2 * (2 * PF + 3 * HT + 7) + 1;
    run_to(kw);
    wr(3, 1, 3'b101);
    check_val("rw_old", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0000FFFF);
    run_to(kw + 1 + FR);
    check_val("rw_new", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h00FF00FF);

    // Reset for three clocks in the middle of a frame.
    run_to(2 * (3 * PF + 20 * HT + 100));
    reset = 1'b1;
    tick();
    tick();
    tick();
    check_reset_outputs("midrst");
    reset = 1'b0;
    tick();
    check_val("restart_rgb",   {8'h0, VGA_R, VGA_G, VGA_B}, 32'h00FF0000);
    check_val("restart_blank", 32'(VGA_BLANK_N), 32'd1);
    check_val("restart_clk",   32'(VGA_CLK), 32'd1);
    run_to(2 * (3 * HT + 7) + 2);
    check_val("kept_rw_new", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h00FF00FF);
    run_to(2 * (3 * HT + 15) + 2);
    check_val("kept_corner", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h000000FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
